// File: rtl/bitvec_index_encoder.sv
// Bit-vector to index-stream encoder: latches a request vector and
// emits one binary index per set bit over a valid/ready stream.
module bitvec_index_encoder #(
   parameter int WIDTH     = 8,
   parameter int IDX_W     = 3,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             zero_vec
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             zero_q, zero_d;

   logic [IDX_W-1:0] sel_idx;
   logic [WIDTH-1:0] sel_oh;
   logic             single;
   logic             fire;
   logic             accept;

   // Priority-select the next bit to emit from the pending set
   always_comb begin
      sel_idx = '0;
      if (LSB_FIRST) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_q[i]) sel_idx = IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (pend_q[i]) sel_idx = IDX_W'(i);
         end
      end
   end

   assign sel_oh = ONE << sel_idx;
   assign single = (pend_q != '0) && ((pend_q & (pend_q - ONE)) == '0);

   assign out_valid = (state_q == SCAN);
   assign out_idx   = out_valid ? sel_idx : '0;
   assign out_last  = out_valid & single;
   assign zero_vec  = zero_q;

   assign fire     = out_valid & out_ready;
   assign in_ready = (state_q == IDLE) | (fire & out_last);
   assign accept   = in_valid & in_ready;

   // Next-state: retire emitted bit, then load a newly accepted vector
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      zero_d  = 1'b0;
      if (fire) begin
         pend_d = pend_q & ~sel_oh;
         if (out_last) state_d = IDLE;
      end
      if (accept) begin
         if (in_vec != '0) begin
            pend_d  = in_vec;
            state_d = SCAN;
         end else begin
            pend_d  = '0;
            state_d = IDLE;
            zero_d  = 1'b1;
         end
      end
   end

   // State, pending-bit and zero-pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         zero_q  <= zero_d;
      end
   end

endmodule

// File: doc/bitvec_index_encoder.md
Name: bitvec_index_encoder

Overview:
- Sequential encoder that converts a WIDTH-bit request vector into a stream of binary bit indices. This is the inverse of the team's 3-to-8 one-hot decoder.
- Each accepted vector is latched. The block then emits one IDX_W-bit index per set bit, in priority order, over a valid/ready output stream.
- It sits between event/interrupt-style bit-vector producers and consumers that want encoded indices, e.g. a downstream decoder or an arbiter log.

Parameters:
- WIDTH, 8: request vector width; must be a power of two, >= 2.
- IDX_W, 3: index width; must equal log2(WIDTH).
- LSB_FIRST, 1: 1 emits the lowest set bit first; 0 emits the highest set bit first.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  in_vec is valid
- in_ready  out  1  block can accept a vector this cycle
- in_vec  in  WIDTH  request vector; any number of bits may be set
- out_valid  out  1  out_idx/out_last are valid
- out_ready  in  1  consumer accepts the current index
- out_idx  out  IDX_W  binary index of the selected set bit
- out_last  out  1  out_idx is the final set bit of the current vector
- zero_vec  out  1  one-cycle pulse: an all-zero vector was accepted and discarded

Behaviour:
- Interface: single clock clk; synchronous active-high reset rst, sampled on the rising edge of clk only.
- States: IDLE (no pending bits) and SCAN (pend register holds remaining bits).
- Reset: state=IDLE, pend=0, out_valid=0, out_idx=0, out_last=0, zero_vec=0, in_ready=1 in the cycle after rst is sampled high.
  - Reset mid-SCAN drops all pending bits; no further out beats are produced.
- Input handshake: a vector is accepted when in_valid && in_ready. in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - in_ready may depend combinationally on out_ready; it has no combinational dependence on in_valid.
- Accept of a nonzero vector: pend <= in_vec and state <= SCAN. The first index is valid the next cycle, giving 1-cycle latency.
- Accept of an all-zero vector: state stays (or returns to) IDLE, no out beat is produced, and zero_vec=1 for exactly the next cycle.
- SCAN outputs:
  - out_valid=1.
  - out_idx is the priority encode of pend: lowest set bit if LSB_FIRST=1, else highest.
  - out_last=1 iff pend has exactly one bit set.
  - out_idx and out_last may be combinational from pend; they must never be combinational from in_* or out_ready.
- In IDLE: out_valid=0, out_last=0, out_idx=0.
- Output handshake (out_valid && out_ready): clear the emitted bit in pend.
  - If out_last, go to IDLE, unless a new vector is accepted in the same cycle. In that case, load it (nonzero) and stay in SCAN with no bubble; a zero vector goes to IDLE and pulses zero_vec.
- Backpressure: while out_valid && !out_ready, pend, out_idx and out_last hold stable. in_valid/in_vec changes are ignored while in_ready=0.
- Throughput: a vector with k set bits occupies k output cycles. Sustained 1 index/cycle with out_ready=1, including across vector boundaries.
- in_vec bits set after acceptance have no effect on the current scan; there is no merging.
- Assertions (bench): out_idx < WIDTH; out_valid implies pend != 0; no out beat is ever issued for a bit absent from the accepted vector.

Test Plan:
- Single bit: in_vec=8'b0000_0001 accepted at cycle N, out_ready=1 -> cycle N+1: out_valid=1, out_idx=0, out_last=1; cycle N+2: out_valid=0, in_ready=1.
- Multi-bit, LSB_FIRST=1: in_vec=8'b1010_0100, out_ready=1 -> out_idx 2, 5, 7 on consecutive cycles, out_last only on 7; in_ready=0 during the 2 and 5 beats.
- Back-to-back: 8'b0000_0110 then 8'b1000_0000 held valid -> beats 1, 2(last), 7(last) with no idle cycle; the second vector is accepted in the same cycle as beat 2.
- Backpressure: 8'b0011_0000 with out_ready=0 for 3 cycles after out_valid rises -> out_idx=4, out_last=0 held 3 cycles; then out_ready=1 -> 4, 5(last).
- Zero vector and MSB order: in_vec=0 -> zero_vec pulse 1 cycle, out_valid stays 0, in_ready stays 1. With LSB_FIRST=0, in_vec=8'hFF -> 8 beats 7..0, out_last on 0.
- Reset mid-scan: 8'b1111_0000, rst=1 after the first beat -> out_valid=0 and in_ready=1 the next cycle; the next vector 8'b0000_1000 yields a single beat 3(last).
